// File: rtl/display_pkg.sv
// Shared constants and state encoding for the multiplexed 7-segment display path.
package display_pkg;

   localparam int N_DIGITS = 8;
   localparam int DIGIT_W  = 3;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } scan_state_t;

endpackage

// File: rtl/lead_zero_mask.sv
// Flags digits that are leading zeros of the displayed hex word.
// Digit 0 is never flagged, so a zero word still shows a single "0".
module lead_zero_mask
   import display_pkg::*;
(
   input  logic [N_DIGITS*NIBBLE_W-1:0] HEX_in,
   input  logic                         lz_suppress,
   output logic [N_DIGITS-1:0]          lz
);

   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      lz = '0;
      for (int i = 1; i < N_DIGITS; i++) begin
         lz[i] = lz_suppress && ((HEX_in >> (i*NIBBLE_W)) == '0);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit 7-segment display.
// Each digit gets a blanking guard followed by a lit slot of fixed length.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int ON_CYCLES    = 100000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [N_DIGITS-1:0]          digit_mask,
   input  logic                         lz_suppress,
   input  logic [N_DIGITS*NIBBLE_W-1:0] HEX_in,
   output logic [DIGIT_W-1:0]           counter,
   output logic [N_DIGITS-1:0]          anodes,
   output logic                         blank,
   output logic                         digit_tick,
   output logic                         frame_tick
);

   localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] ON_LAST    = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
   localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(N_DIGITS - 1);

   scan_state_t          state, stateNext;
   logic [TIMER_W-1:0]   timer, timerNext;
   logic [DIGIT_W-1:0]   counterNext;
   logic [N_DIGITS-1:0]  lzVec;
   logic                 visible;

   lead_zero_mask lzMask (
      .HEX_in      (HEX_in),
      .lz_suppress (lz_suppress),
      .lz          (lzVec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         counter <= '0;
      end else begin
         state   <= stateNext;
         timer   <= timerNext;
         counter <= counterNext;
      end
   end

   // The counter only advances on SHOW->BLANK so the nibble mux and
   // segment decoder settle while all anodes are off.
   always_comb begin
      stateNext   = state;
      timerNext   = timer;
      counterNext = counter;
      if (!enable) begin
         stateNext   = IDLE;
         timerNext   = '0;
         counterNext = '0;
      end else begin
         case (state)
            IDLE: begin
               stateNext   = BLANK;
               timerNext   = '0;
               counterNext = '0;
            end
            BLANK: begin
               if (timer == BLANK_LAST) begin
                  stateNext = SHOW;
                  timerNext = '0;
               end else begin
                  timerNext = timer + TIMER_W'(1);
               end
            end
            SHOW: begin
               if (timer == ON_LAST) begin
                  stateNext   = BLANK;
                  timerNext   = '0;
                  counterNext = counter + DIGIT_W'(1);
               end else begin
                  timerNext = timer + TIMER_W'(1);
               end
            end
            default: begin
               stateNext   = IDLE;
               timerNext   = '0;
               counterNext = '0;
            end
         endcase
      end
   end

   // Hidden digits keep their full slot so lit digits stay equally bright.
   always_comb begin
      visible    = (state == SHOW) && digit_mask[counter] && !lzVec[counter];
      anodes     = visible ? ~(N_DIGITS'(1) << counter) : '1;
      blank      = !visible;
      digit_tick = (state == SHOW) && (timer == ON_LAST);
      frame_tick = digit_tick && (counter == LAST_DIGIT);
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with short slot timing.
module tb_display_scan_ctrl;

   localparam int ON_CYCLES    = 4;
   localparam int BLANK_CYCLES = 2;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [7:0]  digit_mask;
   logic        lz_suppress;
   logic [31:0] HEX_in;
   logic [2:0]  counter;
   logic [7:0]  anodes;
   logic        blank;
   logic        digit_tick;
   logic        frame_tick;

   int checkCount = 0;
   int passCount  = 0;

   logic [7:0] lowCode [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   display_scan_ctrl #(
      .ON_CYCLES    (ON_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .digit_mask  (digit_mask),
      .lz_suppress (lz_suppress),
      .HEX_in      (HEX_in),
      .counter     (counter),
      .anodes      (anodes),
      .blank       (blank),
      .digit_tick  (digit_tick),
      .frame_tick  (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic en, input logic [7:0] msk,
                                input logic lzs, input logic [31:0] hex);
      enable      = en;
      digit_mask  = msk;
      lz_suppress = lzs;
      HEX_in      = hex;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] expAnodes,
                              input logic expBlank, input logic [2:0] expCounter,
                              input logic expDigit, input logic expFrame);
      checkCount++;
      assert (anodes === expAnodes) passCount++;
      else $error("FAIL %s anodes got %h want %h", tag, anodes, expAnodes);
      checkCount++;
      assert (blank === expBlank) passCount++;
      else $error("FAIL %s blank got %b want %b", tag, blank, expBlank);
      checkCount++;
      assert (counter === expCounter) passCount++;
      else $error("FAIL %s counter got %0d want %0d", tag, counter, expCounter);
      checkCount++;
      assert (digit_tick === expDigit) passCount++;
      else $error("FAIL %s digit_tick got %b want %b", tag, digit_tick, expDigit);
      checkCount++;
      assert (frame_tick === expFrame) passCount++;
      else $error("FAIL %s frame_tick got %b want %b", tag, frame_tick, expFrame);
   endtask

   task automatic blankPhase(input int d);
      for (int k = 0; k < BLANK_CYCLES; k++) begin
         @(negedge clk);
         checkOutput($sformatf("blank d%0d k%0d", d, k), 8'hFF, 1'b1, 3'(d), 1'b0, 1'b0);
      end
   endtask

   task automatic showCycle(input int d, input bit vis, input int k);
      bit last;
      last = (k == ON_CYCLES-1);
      @(negedge clk);
      checkOutput($sformatf("show d%0d k%0d", d, k), vis ? lowCode[d] : 8'hFF,
                  !vis, 3'(d), last, last && (d == 7));
   endtask

   task automatic expectSlot(input int d, input bit vis);
      blankPhase(d);
      for (int k = 0; k < ON_CYCLES; k++) showCycle(d, vis, k);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 8'hFF, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("reset", 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle", 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);

      // Basic scan and full frame walk, including 7->0 wrap.
      applyStimulus(1'b1, 8'hFF, 1'b0, 32'h0);
      for (int d = 0; d < 8; d++) expectSlot(d, 1'b1);
      expectSlot(0, 1'b1);

      // Leading-zero suppression.
      applyStimulus(1'b1, 8'hFF, 1'b1, 32'h0000_00A5);
      expectSlot(1, 1'b1);
      for (int d = 2; d < 8; d++) expectSlot(d, 1'b0);
      expectSlot(0, 1'b1);
      applyStimulus(1'b1, 8'hFF, 1'b1, 32'h0);
      for (int d = 1; d < 8; d++) expectSlot(d, 1'b0);
      expectSlot(0, 1'b1);

      // Digit mask, with a mask change in the middle of digit 5.
      applyStimulus(1'b1, 8'h0F, 1'b0, 32'h0);
      for (int d = 1; d < 4; d++) expectSlot(d, 1'b1);
      expectSlot(4, 1'b0);
      blankPhase(5);
      showCycle(5, 1'b0, 0);
      showCycle(5, 1'b0, 1);
      applyStimulus(1'b1, 8'hFF, 1'b0, 32'h0);
      #1;
      checkOutput("mask same cycle", 8'hDF, 1'b0, 3'd5, 1'b0, 1'b0);
      showCycle(5, 1'b1, 2);
      showCycle(5, 1'b1, 3);
      expectSlot(6, 1'b1);
      expectSlot(7, 1'b1);
      expectSlot(0, 1'b1);

      // Enable dropped mid-SHOW of digit 3.
      expectSlot(1, 1'b1);
      expectSlot(2, 1'b1);
      blankPhase(3);
      showCycle(3, 1'b1, 0);
      showCycle(3, 1'b1, 1);
      applyStimulus(1'b0, 8'hFF, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("disable", 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0, 32'h0);
      expectSlot(0, 1'b1);

      // Reset mid-SHOW with enable held high.
      expectSlot(1, 1'b1);
      blankPhase(2);
      showCycle(2, 1'b1, 0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("reset mid show", 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reset held", 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      expectSlot(0, 1'b1);
      expectSlot(1, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
